pc_redirect_ctrl: RTL and testbench

- Sequences the 27-bit fetch program counter register.
- Each cycle it decides whether the PC advances by +4, holds, or loads a redirect target.
- Redirect sources: trap, EX-stage branch/jalr, ID-stage jal, and loader completion.
- Sits between the pipeline hazard/branch logic and the PC register. Drives that register's npc, npc_enn and n_stall inputs, plus pipeline flushes.

---
 rtl/pc_ctrl_pkg.sv | 24 ++
 rtl/redirect_prio_sel.sv | 49 ++++
 rtl/pc_redirect_ctrl.sv | 131 +++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared types and constants for the PC redirect controller
package pc_ctrl_pkg;

  localparam int PC_W = 27;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } pc_state_e;

  localparam logic [1:0] RANK_NONE = 2'd0;
  localparam logic [1:0] RANK_ID   = 2'd1;
  localparam logic [1:0] RANK_EX   = 2'd2;
  localparam logic [1:0] RANK_TRAP = 2'd3;

  typedef struct packed {
    logic            valid;
    logic [1:0]      rank;
    logic [PC_W-1:0] target;
  } redirect_t;

endpackage

// File: rtl/redirect_prio_sel.sv
// rtl/redirect_prio_sel.sv - picks the winning redirect among pending, trap, ex, loader and id
module redirect_prio_sel
  import pc_ctrl_pkg::*;
#(
  parameter logic [PC_W-1:0] ENTRY_PC = '0
) (
  input  logic            in_boot,
  input  redirect_t       pend,
  input  logic            trap_valid,
  input  logic [PC_W-1:0] trap_target,
  input  logic            ex_br_valid,
  input  logic [PC_W-1:0] ex_br_target,
  input  logic            loader_done,
  input  logic            id_jmp_valid,
  input  logic [PC_W-1:0] id_jmp_target,
  output redirect_t       cand,
  output logic            cand_loader
);

  redirect_t fresh;
  logic      fresh_loader;

  // Same-cycle winner; ex is checked before loader so it wins the rank-2 tie
  always_comb begin
    fresh        = '0;
    fresh_loader = 1'b0;
    if (trap_valid) begin
      fresh = '{valid: 1'b1, rank: RANK_TRAP, target: trap_target};
    end else if (ex_br_valid) begin
      fresh = '{valid: 1'b1, rank: RANK_EX, target: ex_br_target};
    end else if (loader_done && in_boot) begin
      fresh        = '{valid: 1'b1, rank: RANK_EX, target: ENTRY_PC};
      fresh_loader = 1'b1;
    end else if (id_jmp_valid) begin
      fresh = '{valid: 1'b1, rank: RANK_ID, target: id_jmp_target};
    end
  end

  // A fresh request replaces the pending one only if it is at least as strong
  always_comb begin
    cand        = pend;
    cand_loader = 1'b0;
    if (fresh.valid && (!pend.valid || fresh.rank >= pend.rank)) begin
      cand        = fresh;
      cand_loader = fresh_loader;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - fetch PC sequencer: +4, hold or redirect; optional PC_REDIRECT_PERF_EN counters
module pc_redirect_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = PC_W,
  parameter logic [ADDR_W-1:0] RESET_PC = 27'd16308,
  parameter logic [ADDR_W-1:0] ENTRY_PC = 27'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_if,
  input  logic              stall_pipe,
  input  logic              halt_req,
  input  logic              resume,
  input  logic              loader_done,
  input  logic              id_jmp_valid,
  input  logic [ADDR_W-1:0] id_jmp_target,
  input  logic              ex_br_valid,
  input  logic [ADDR_W-1:0] ex_br_target,
  input  logic              trap_valid,
  input  logic [ADDR_W-1:0] trap_target,
  output logic [ADDR_W-1:0] npc,
  output logic              npc_enn,
  output logic              pc_n_stall,
  output logic              flush_if_id,
  output logic              flush_id_ex,
`ifdef PC_REDIRECT_PERF_EN
  output logic [31:0]       perf_redirects,
  output logic [31:0]       perf_stall_cycles,
`endif
  output logic [1:0]        state_o
);

  pc_state_e state, state_nx;
  redirect_t pend, pend_nx, cand;
  logic      cand_loader;
  logic      stalled, run_en, apply, latch;

  assign stalled = stall_if | stall_pipe;
  assign run_en  = ~stalled & (state != HALT);
  assign apply   = run_en & cand.valid;
  assign latch   = ~run_en & cand.valid;

  redirect_prio_sel #(.ENTRY_PC(ENTRY_PC)) u_sel (
    .in_boot      (state == BOOT),
    .pend         (pend),
    .trap_valid   (trap_valid),
    .trap_target  (trap_target),
    .ex_br_valid  (ex_br_valid),
    .ex_br_target (ex_br_target),
    .loader_done  (loader_done),
    .id_jmp_valid (id_jmp_valid),
    .id_jmp_target(id_jmp_target),
    .cand         (cand),
    .cand_loader  (cand_loader)
  );

  // State and pending-redirect registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      pend  <= '0;
    end else begin
      state <= state_nx;
      pend  <= pend_nx;
    end
  end

  // Next state; halt_req overrides the destination but the redirect is still applied or latched
  always_comb begin
    state_nx = state;
    pend_nx  = pend;
    if (apply) begin
      pend_nx = '0;
    end else if (latch) begin
      pend_nx = cand;
    end
    case (state)
      BOOT: begin
        if (apply && cand_loader) state_nx = RUN;
        else if (latch)           state_nx = HOLD;
      end
      RUN: begin
        if (halt_req)   state_nx = HALT;
        else if (latch) state_nx = HOLD;
      end
      HOLD: begin
        if (halt_req)     state_nx = HALT;
        else if (!stalled) state_nx = RUN;
      end
      HALT: begin
        if (resume) state_nx = cand.valid ? HOLD : RUN;
      end
      default: state_nx = BOOT;
    endcase
  end

  // Outputs to the PC register and pipeline latches; quiet while in reset
  always_comb begin
    npc         = '0;
    npc_enn     = 1'b0;
    pc_n_stall  = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    state_o     = 2'd0;
    if (rst) begin
      npc = RESET_PC;
    end else begin
      pc_n_stall  = run_en;
      npc_enn     = apply;
      npc         = apply ? cand.target : '0;
      flush_if_id = cand.valid;
      flush_id_ex = cand.valid && (cand.rank >= RANK_EX);
      state_o     = state;
    end
  end

`ifdef PC_REDIRECT_PERF_EN
  // Free-running event counters, wrap naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_redirects    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (apply)                        perf_redirects    <= perf_redirects + 32'd1;
      if (stalled && (state != HALT))   perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - directed self-checking bench for pc_redirect_ctrl
module tb_pc_redirect_ctrl;

  localparam int AW = 27;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall_if, stall_pipe, halt_req, resume, loader_done;
  logic          id_jmp_valid, ex_br_valid, trap_valid;
  logic [AW-1:0] id_jmp_target, ex_br_target, trap_target;
  logic [AW-1:0] npc;
  logic          npc_enn, pc_n_stall, flush_if_id, flush_id_ex;
  logic [1:0]    state_o;
`ifdef PC_REDIRECT_PERF_EN
  logic [31:0]   perf_redirects, perf_stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .stall_if         (stall_if),
    .stall_pipe       (stall_pipe),
    .halt_req         (halt_req),
    .resume           (resume),
    .loader_done      (loader_done),
    .id_jmp_valid     (id_jmp_valid),
    .id_jmp_target    (id_jmp_target),
    .ex_br_valid      (ex_br_valid),
    .ex_br_target     (ex_br_target),
    .trap_valid       (trap_valid),
    .trap_target      (trap_target),
    .npc              (npc),
    .npc_enn          (npc_enn),
    .pc_n_stall       (pc_n_stall),
    .flush_if_id      (flush_if_id),
    .flush_id_ex      (flush_id_ex),
`ifdef PC_REDIRECT_PERF_EN
    .perf_redirects   (perf_redirects),
    .perf_stall_cycles(perf_stall_cycles),
`endif
    .state_o          (state_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the next negedge with all request pulses cleared
  task automatic next_cycle();
    @(negedge clk);
    halt_req = 0; resume = 0; loader_done = 0;
    id_jmp_valid = 0; ex_br_valid = 0; trap_valid = 0;
    id_jmp_target = '0; ex_br_target = '0; trap_target = '0;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1; stall_if = 0; stall_pipe = 0;
    halt_req = 0; resume = 0; loader_done = 0;
    id_jmp_valid = 0; ex_br_valid = 0; trap_valid = 0;
    id_jmp_target = '0; ex_br_target = '0; trap_target = '0;

    // Reset
    @(posedge clk);
    next_cycle(); settle();
    chk("rst_npc", 32'(npc), 32'd16308);
    chk("rst_nstall", 32'(pc_n_stall), 0);
    chk("rst_enn", 32'(npc_enn), 0);
    chk("rst_flush", 32'({flush_if_id, flush_id_ex}), 0);
    chk("rst_state", 32'(state_o), 0);

    // Release, idle
    next_cycle(); rst = 0; settle();
    chk("rel_nstall", 32'(pc_n_stall), 1);
    chk("rel_enn", 32'(npc_enn), 0);
    chk("rel_state", 32'(state_o), 0);

    // Loader done in BOOT
    next_cycle(); loader_done = 1; settle();
    chk("ld_npc", 32'(npc), 0);
    chk("ld_enn", 32'(npc_enn), 1);
    chk("ld_fex", 32'(flush_id_ex), 1);
    chk("ld_fif", 32'(flush_if_id), 1);
    next_cycle(); settle();
    chk("ld_run", 32'(state_o), 1);
    chk("ld_idle_enn", 32'(npc_enn), 0);

    // loader_done outside BOOT ignored
    next_cycle(); loader_done = 1; settle();
    chk("ld_ign_enn", 32'(npc_enn), 0);
    chk("ld_ign_fif", 32'(flush_if_id), 0);

    // A: ex during 3-cycle stall, applied on unstall
    next_cycle(); stall_pipe = 1; ex_br_valid = 1; ex_br_target = 27'h100; settle();
    chk("A1_enn", 32'(npc_enn), 0);
    chk("A1_nstall", 32'(pc_n_stall), 0);
    chk("A1_fex", 32'(flush_id_ex), 1);
    next_cycle(); settle();
    chk("A2_state", 32'(state_o), 2);
    chk("A2_enn", 32'(npc_enn), 0);
    next_cycle(); settle();
    chk("A3_state", 32'(state_o), 2);
    next_cycle(); stall_pipe = 0; settle();
    chk("A4_npc", 32'(npc), 32'h100);
    chk("A4_enn", 32'(npc_enn), 1);
    next_cycle(); settle();
    chk("A5_state", 32'(state_o), 1);
    chk("A5_enn", 32'(npc_enn), 0);

    // B: id cannot displace pending ex
    next_cycle(); stall_if = 1; ex_br_valid = 1; ex_br_target = 27'h100; settle();
    next_cycle(); id_jmp_valid = 1; id_jmp_target = 27'h200; settle();
    chk("B2_fex", 32'(flush_id_ex), 1);
    chk("B2_enn", 32'(npc_enn), 0);
    next_cycle(); stall_if = 0; settle();
    chk("B3_npc", 32'(npc), 32'h100);
    chk("B3_enn", 32'(npc_enn), 1);

    // C: trap overrides pending ex
    next_cycle(); stall_pipe = 1; ex_br_valid = 1; ex_br_target = 27'h100; settle();
    next_cycle(); stall_pipe = 0; trap_valid = 1; trap_target = 27'h40; settle();
    chk("C2_npc", 32'(npc), 32'h40);
    chk("C2_enn", 32'(npc_enn), 1);
    next_cycle(); settle();
    chk("C3_state", 32'(state_o), 1);

    // D: same-cycle ranking
    next_cycle(); id_jmp_valid = 1; id_jmp_target = 27'h80;
    ex_br_valid = 1; ex_br_target = 27'h90; trap_valid = 1; trap_target = 27'h44; settle();
    chk("D1_npc", 32'(npc), 32'h44);
    chk("D1_fif", 32'(flush_if_id), 1);
    chk("D1_fex", 32'(flush_id_ex), 1);
    next_cycle(); id_jmp_valid = 1; id_jmp_target = 27'h80;
    ex_br_valid = 1; ex_br_target = 27'h90; settle();
    chk("D2_npc", 32'(npc), 32'h90);
    next_cycle(); id_jmp_valid = 1; id_jmp_target = 27'h80; settle();
    chk("D3_npc", 32'(npc), 32'h80);
    chk("D3_fif", 32'(flush_if_id), 1);
    chk("D3_fex", 32'(flush_id_ex), 0);
    next_cycle(); trap_valid = 1; trap_target = 27'h43; settle();
    chk("D4_unaligned", 32'(npc), 32'h43);

    // E: halt, latch in HALT, resume through HOLD
    next_cycle(); halt_req = 1; settle();
    chk("E1_nstall", 32'(pc_n_stall), 1);
    chk("E1_state", 32'(state_o), 1);
    next_cycle(); ex_br_valid = 1; ex_br_target = 27'h300; settle();
    chk("E2_state", 32'(state_o), 3);
    chk("E2_nstall", 32'(pc_n_stall), 0);
    chk("E2_enn", 32'(npc_enn), 0);
    chk("E2_fex", 32'(flush_id_ex), 1);
    next_cycle(); halt_req = 1; settle();
    chk("E3_state", 32'(state_o), 3);
    next_cycle(); resume = 1; settle();
    chk("E4_state", 32'(state_o), 3);
    chk("E4_nstall", 32'(pc_n_stall), 0);
    next_cycle(); settle();
    chk("E5_state", 32'(state_o), 2);
    chk("E5_npc", 32'(npc), 32'h300);
    chk("E5_enn", 32'(npc_enn), 1);
    next_cycle(); settle();
    chk("E6_state", 32'(state_o), 1);

    // F: reset mid-HOLD drops the pending redirect
    next_cycle(); stall_pipe = 1; ex_br_valid = 1; ex_br_target = 27'h500; settle();
    next_cycle(); settle();
    chk("F1_state", 32'(state_o), 2);
    next_cycle(); rst = 1; settle();
    chk("F2_npc", 32'(npc), 32'd16308);
    chk("F2_enn", 32'(npc_enn), 0);
    next_cycle(); rst = 0; stall_pipe = 0; settle();
    chk("F3_state", 32'(state_o), 0);
    chk("F3_enn", 32'(npc_enn), 0);
    chk("F3_fif", 32'(flush_if_id), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
